// File: rtl/hold_pkg.sv
// Shared definitions for the retriggerable pulse-stretcher array: state codes,
// default counter width and the hold-length normalisation rule.
package hold_pkg;

    localparam logic ST_IDLE = 1'b0;
    localparam logic ST_HOLD = 1'b1;

    localparam int DEF_CNT_W = 8;

    // A programmed length of zero still yields a one-cycle window.
    function automatic int unsigned eff_len(input int unsigned len);
        return (len == 0) ? 1 : len;
    endfunction

endpackage

// File: rtl/hold_chan.sv
// One stretcher channel: optional rising-edge detect, IDLE/HOLD state,
// down-counter and a registered one-cycle done pulse.
module hold_chan
    import hold_pkg::*;
#(
    parameter int CNT_W     = DEF_CNT_W,
    parameter int EDGE_MODE = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             retrig,
    input  logic [CNT_W-1:0] hold_len,
    input  logic             trick,
    output logic             hold,
    output logic             done
);

    logic             state;
    logic [CNT_W-1:0] cnt;
    logic             prev;
    logic             trig;
    logic [CNT_W-1:0] reload;

    // prev clears on reset, so an input already high after reset is an edge.
    assign trig   = (EDGE_MODE != 0) ? (trick & ~prev) : trick;
    assign reload = CNT_W'(eff_len(32'(hold_len)) - 32'd1);
    assign hold   = state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            cnt   <= '0;
            prev  <= 1'b0;
            done  <= 1'b0;
        end else begin
            prev <= trick;
            done <= 1'b0;
            if (clr) begin
                state <= ST_IDLE;
                cnt   <= '0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (trig) begin
                            state <= ST_HOLD;
                            cnt   <= reload;
                        end
                    end
                    default: begin
                        // Reloading on the final count keeps the window unbroken.
                        if (retrig && trig) begin
                            cnt <= reload;
                        end else if (cnt != '0) begin
                            cnt <= cnt - 1'b1;
                        end else begin
                            state <= ST_IDLE;
                            done  <= 1'b1;
                        end
                    end
                endcase
            end
        end
    end

endmodule

// File: rtl/hold_array.sv
// Multi-channel retriggerable pulse stretcher: CHANNELS independent hold_chan
// instances sharing hold length, clear and retrigger controls.
module hold_array
    import hold_pkg::*;
#(
    parameter int CHANNELS  = 4,
    parameter int CNT_W     = DEF_CNT_W,
    parameter int EDGE_MODE = 0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                clr,
    input  logic                retrig,
    input  logic [CNT_W-1:0]    hold_len_i,
    input  logic [CHANNELS-1:0] trick_i,
    output logic [CHANNELS-1:0] trick_o,
    output logic [CHANNELS-1:0] done_o,
    output logic                busy_o
);

    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_chan
        hold_chan #(
            .CNT_W     (CNT_W),
            .EDGE_MODE (EDGE_MODE)
        ) u_chan (
            .clk      (clk),
            .rst_n    (rst_n),
            .clr      (clr),
            .retrig   (retrig),
            .hold_len (hold_len_i),
            .trick    (trick_i[gi]),
            .hold     (trick_o[gi]),
            .done     (done_o[gi])
        );
    end

    assign busy_o = |trick_o;

endmodule

// File: tb/tb_hold_array.sv
// Bench for hold_array: a level-triggered and an edge-triggered instance share
// stimulus and are compared every cycle against a window-end-time model.
module tb_hold_array;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       clr;
    logic       retrig;
    logic [7:0] hold_len;
    logic [3:0] trick_i;
    logic [3:0] trick_o0, done_o0, trick_o1, done_o1;
    logic       busy0, busy1;

    int vectors = 0;
    int miscompares = 0;

    // Model: each channel's window is described by the last cycle it is high.
    int         cyc;
    int         hend0 [4];
    int         hend1 [4];
    logic [3:0] prev_m;
    logic [3:0] exp_o0, exp_d0, exp_o1, exp_d1;

    always #5 clk = ~clk;

    hold_array #(.CHANNELS(4), .CNT_W(8), .EDGE_MODE(0)) dut_lvl (
        .clk(clk), .rst_n(rst_n), .clr(clr), .retrig(retrig), .hold_len_i(hold_len),
        .trick_i(trick_i), .trick_o(trick_o0), .done_o(done_o0), .busy_o(busy0)
    );

    hold_array #(.CHANNELS(4), .CNT_W(8), .EDGE_MODE(1)) dut_edg (
        .clk(clk), .rst_n(rst_n), .clr(clr), .retrig(retrig), .hold_len_i(hold_len),
        .trick_i(trick_i), .trick_o(trick_o1), .done_o(done_o1), .busy_o(busy1)
    );

    function automatic logic [17:0] observed();
        return {trick_o0, done_o0, busy0, trick_o1, done_o1, busy1};
    endfunction

    function automatic logic [17:0] expected();
        return {exp_o0, exp_d0, |exp_o0, exp_o1, exp_d1, |exp_o1};
    endfunction

    task automatic model_reset();
        cyc = 0;
        prev_m = '0;
        exp_o0 = '0; exp_d0 = '0; exp_o1 = '0; exp_d1 = '0;
        for (int k = 0; k < 4; k++) begin
            hend0[k] = -1;
            hend1[k] = -1;
        end
    endtask

    // Advance one clock edge (inputs already driven) and update the model.
    task automatic tick();
        int  len;
        logic trg, hn, nw;
        @(posedge clk);
        if (!rst_n) begin
            model_reset();
        end else begin
            len = (hold_len == 0) ? 1 : int'(hold_len);
            for (int k = 0; k < 4; k++) begin
                trg = trick_i[k];
                hn  = exp_o0[k];
                if (clr) hend0[k] = -1;
                else if (trg && (!hn || retrig)) hend0[k] = cyc + len;
                nw = (cyc + 1 <= hend0[k]);
                exp_d0[k] = hn && !nw && !clr;
                exp_o0[k] = nw;

                trg = trick_i[k] & ~prev_m[k];
                hn  = exp_o1[k];
                if (clr) hend1[k] = -1;
                else if (trg && (!hn || retrig)) hend1[k] = cyc + len;
                nw = (cyc + 1 <= hend1[k]);
                exp_d1[k] = hn && !nw && !clr;
                exp_o1[k] = nw;
            end
            prev_m = trick_i;
            cyc++;
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; clr = 1'b0; retrig = 1'b0; hold_len = 8'd5; trick_i = 4'hF;
        model_reset();
        repeat (3) @(negedge clk);
        vectors++;
        if (observed() !== 18'd0) begin
            miscompares++;
            $display("FAIL reset_state got=%h exp=%h", observed(), 18'd0);
        end
        trick_i = '0;
        rst_n = 1'b1;
        repeat (4) begin
            tick();
            vectors++;
            if (observed() !== expected()) begin
                miscompares++;
                $display("FAIL reset_idle cyc=%0d got=%h exp=%h", cyc, observed(), expected());
            end
        end
    endtask

    task automatic test_basic();
        int n, hi, dcyc, dcnt;
        hold_len = 8'd5; retrig = 1'b0;
        hi = 0; dcnt = 0; dcyc = -1;
        repeat (3) tick();
        n = cyc;
        trick_i = 4'b0001;
        for (int i = 0; i < 12; i++) begin
            tick();
            trick_i = '0;
            if (trick_o0[0]) hi++;
            if (done_o0[0]) begin dcnt++; dcyc = cyc; end
            vectors++;
            if (observed() !== expected()) begin
                miscompares++;
                $display("FAIL basic cyc=%0d got=%h exp=%h", cyc, observed(), expected());
            end
        end
        vectors++;
        if (hi !== 5 || dcnt !== 1 || dcyc !== n + 6) begin
            miscompares++;
            $display("FAIL basic_window high=%0d done=%0d@%0d exp 5 1@%0d", hi, dcnt, dcyc, n + 6);
        end
    endtask

    task automatic test_len_extremes();
        int hi;
        hold_len = 8'd0; retrig = 1'b0; hi = 0;
        trick_i = 4'b0010;
        for (int i = 0; i < 5; i++) begin
            tick();
            trick_i = '0;
            if (trick_o0[1]) hi++;
            vectors++;
            if (observed() !== expected()) begin
                miscompares++;
                $display("FAIL len0 cyc=%0d got=%h exp=%h", cyc, observed(), expected());
            end
        end
        vectors++;
        if (hi !== 1) begin
            miscompares++;
            $display("FAIL len0_width got=%0d exp=1", hi);
        end
        hold_len = 8'd255; hi = 0;
        trick_i = 4'b0100;
        for (int i = 0; i < 262; i++) begin
            tick();
            trick_i = '0;
            if (trick_o1[2]) hi++;
            vectors++;
            if (observed() !== expected()) begin
                miscompares++;
                $display("FAIL len255 cyc=%0d got=%h exp=%h", cyc, observed(), expected());
            end
        end
        vectors++;
        if (hi !== 255) begin
            miscompares++;
            $display("FAIL len255_width got=%0d exp=255", hi);
        end
    endtask

    task automatic test_retrig();
        int hi, dcnt;
        hold_len = 8'd4;
        for (int r = 1; r >= 0; r--) begin
            retrig = r[0]; hi = 0; dcnt = 0;
            for (int i = 0; i < 14; i++) begin
                trick_i = (i == 0 || i == 3) ? 4'b0001 : 4'b0000;
                tick();
                if (trick_o0[0]) hi++;
                if (done_o0[0]) dcnt++;
                vectors++;
                if (observed() !== expected()) begin
                    miscompares++;
                    $display("FAIL retrig%0d cyc=%0d got=%h exp=%h", r, cyc, observed(), expected());
                end
            end
            vectors++;
            if (hi !== (r ? 7 : 4) || dcnt !== 1) begin
                miscompares++;
                $display("FAIL retrig%0d_window high=%0d done=%0d exp %0d 1", r, hi, dcnt, r ? 7 : 4);
            end
        end
        trick_i = '0; retrig = 1'b0;
    endtask

    task automatic test_level_hold();
        int rises;
        logic last;
        hold_len = 8'd3; retrig = 1'b0; rises = 0; last = 1'b0;
        for (int i = 0; i < 26; i++) begin
            trick_i = (i < 20) ? 4'b0100 : 4'b0000;
            tick();
            if (trick_o1[2] && !last) rises++;
            last = trick_o1[2];
            vectors++;
            if (observed() !== expected()) begin
                miscompares++;
                $display("FAIL level_hold cyc=%0d got=%h exp=%h", cyc, observed(), expected());
            end
        end
        vectors++;
        if (rises !== 1) begin
            miscompares++;
            $display("FAIL edge_single_window got=%0d exp=1", rises);
        end
    endtask

    task automatic test_clr();
        hold_len = 8'd8; retrig = 1'b0;
        for (int i = 0; i < 12; i++) begin
            trick_i = (i == 0) ? 4'b1000 : 4'b0000;
            clr     = (i == 2);
            tick();
            vectors++;
            if (observed() !== expected()) begin
                miscompares++;
                $display("FAIL clr cyc=%0d got=%h exp=%h", cyc, observed(), expected());
            end
        end
        clr = 1'b0;
    endtask

    task automatic test_async_reset();
        hold_len = 8'd20;
        trick_i = 4'hF;
        repeat (5) tick();
        trick_i = '0;
        #2 rst_n = 1'b0;
        #1;
        vectors++;
        if (observed() !== 18'd0) begin
            miscompares++;
            $display("FAIL async_reset got=%h exp=%h", observed(), 18'd0);
        end
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) begin
            tick();
            vectors++;
            if (observed() !== expected()) begin
                miscompares++;
                $display("FAIL post_reset cyc=%0d got=%h exp=%h", cyc, observed(), expected());
            end
        end
    endtask

    task automatic test_simultaneous();
        for (int i = 0; i < 20; i++) begin
            trick_i  = (i == 0) ? 4'hF : ((i == 2) ? 4'b0101 : 4'b0000);
            hold_len = (i == 0) ? 8'd3 : 8'(i + 4);
            retrig   = 1'b0;
            tick();
            vectors++;
            if (observed() !== expected()) begin
                miscompares++;
                $display("FAIL simultaneous cyc=%0d got=%h exp=%h", cyc, observed(), expected());
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            if (i % 25 == 0) retrig = 1'($urandom_range(0, 1));
            for (int k = 0; k < 4; k++) trick_i[k] = ($urandom_range(0, 5) == 0);
            hold_len = ($urandom_range(0, 9) == 0) ? 8'd0 : 8'($urandom_range(1, 9));
            clr = ($urandom_range(0, 40) == 0);
            tick();
            vectors++;
            if (observed() !== expected()) begin
                miscompares++;
                $display("FAIL random cyc=%0d got=%h exp=%h", cyc, observed(), expected());
            end
        end
        clr = 1'b0; trick_i = '0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_len_extremes();
        test_retrig();
        test_level_hold();
        test_clr();
        test_async_reset();
        test_simultaneous();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
